cosim_vec_gen: RTL
==================

COSIM_VEC_GEN -- requirements
Module: cosim_vec_gen

Interface
REQ-001 The block SHALL have parameter NUM_RANDOM, default 1000, setting the number of pseudo-random vectors; legal range 1..65531.
REQ-002 The block SHALL have parameter SEED, default 128'h1, setting the nonzero LFSR seed.
REQ-003 Port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-004 Port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-005 Port start, input, 1 bit: begins a vector run.
REQ-006 Port vec_valid, output, 1 bit: vec_data holds a vector.
REQ-007 Port vec_ready, input, 1 bit: the downstream comparison stage accepts the vector.
REQ-008 Port vec_data, output, 128 bits: stimulus word, split downstream as {a9, a4, a1, b9, b6, b2}.
REQ-009 Port vec_idx, output, 16 bits: index of the vector currently on vec_data.
REQ-010 Port done, output, 1 bit: the run is complete.

Function
REQ-011 The FSM SHALL have exactly the states IDLE, CORNER, RANDOM and DONE.
REQ-012 In IDLE or DONE, start=1 SHALL move to CORNER on the next edge, reload the LFSR with SEED, clear vec_idx, clear done and set vec_valid=1.
REQ-013 start SHALL be ignored in CORNER and RANDOM.
REQ-014 Acceptance SHALL occur only on a cycle with vec_valid=1 and vec_ready=1.
REQ-015 On each acceptance, vec_idx SHALL increment by 1 and the next vector SHALL appear on the following cycle with no bubble.
REQ-016 While vec_valid=1 and vec_ready=0, vec_data and vec_idx SHALL hold stable.
REQ-017 CORNER SHALL emit, in order: 128'h0, all-ones, 128'h5555...5, then 128'hAAAA...A.
REQ-018 Acceptance of the fourth corner vector SHALL enter RANDOM.
REQ-019 The first RANDOM vector SHALL be SEED.
REQ-020 Each later RANDOM vector SHALL be next(s) = {s[126:0],1'b0} XOR (s[127] ? 128'h87 : 128'h0), i.e. polynomial x^128+x^7+x^2+x+1.
REQ-021 The LFSR SHALL advance only on acceptance.
REQ-022 Acceptance of vector index 3+NUM_RANDOM SHALL enter DONE on the same edge that sets vec_valid=0 and done=1.
REQ-023 In DONE, vec_data and vec_idx SHALL retain their last values.
REQ-024 Total vectors per run SHALL be 4+NUM_RANDOM; vec_idx never wraps within a run.
REQ-025 Start-to-first-valid latency SHALL be exactly 1 cycle.
REQ-026 vec_valid SHALL not depend combinationally on vec_ready.

Reset
REQ-027 rst_n=0 SHALL immediately force state=IDLE, vec_valid=0, vec_data=0, vec_idx=0, done=0 and LFSR=SEED, including mid-run.
REQ-028 After rst_n rises, the block SHALL remain in IDLE until start=1 is sampled.

Structure
REQ-029 Shared package cosim_pkg SHALL hold the FSM state enum, the four corner-pattern constants, the polynomial constant 128'h87 and the function lfsr128_next.
REQ-030 The LFSR SHALL be a single sub-module, cosim_lfsr128, with ports clk, rst_n, load, seed, step and q.
REQ-031 All outputs SHALL be registered.

Verification
REQ-032 NUM_RANDOM=2, SEED=1, vec_ready=1, start pulsed -> vectors 0, all-ones, 5..5, A..A, 128'h1, 128'h2 at vec_idx 0..5; done=1 the cycle after vec_idx 5 is accepted.
REQ-033 vec_ready=0 for 3 cycles at vec_idx 2 -> vec_data holds 128'h5555...5 and vec_idx holds 2; vec_idx 3 follows 1 cycle after ready rises.
REQ-034 SEED=128'h8000...0, NUM_RANDOM=2 -> random vectors 128'h8000...0 then 128'h87.
REQ-035 rst_n dropped while vec_idx=5 in RANDOM -> all outputs are 0 without waiting for a clock edge; a new start restarts at vec_idx 0 with 128'h0.
REQ-036 start pulsed during CORNER -> the sequence is unaffected; start pulsed in DONE -> the run restarts and done clears on the next edge.

Source files
------------

// File: rtl/cosim_pkg.sv
// cosim_pkg: shared definitions for the co-simulation vector generator.
//   - state_e       : generator FSM states
//   - CORNER_*      : the four fixed corner-case stimulus words
//   - LFSR_POLY     : feedback taps for x^128 + x^7 + x^2 + x + 1
//   - lfsr128_next  : one Galois step of the 128-bit LFSR
//   - corner_pat    : maps a corner index (0..3) to its pattern
package cosim_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CORNER = 2'd1,
    RANDOM = 2'd2,
    DONE   = 2'd3
  } state_e;

  localparam logic [127:0] CORNER_ZERO = 128'h0;
  localparam logic [127:0] CORNER_ONES = {128{1'b1}};
  localparam logic [127:0] CORNER_FIVE = {32{4'h5}};
  localparam logic [127:0] CORNER_A    = {32{4'hA}};

  localparam logic [127:0] LFSR_POLY = 128'h87;

  // Left shift; when the MSB falls out, fold it back in through the low taps.
  function automatic logic [127:0] lfsr128_next(input logic [127:0] s);
    return {s[126:0], 1'b0} ^ (s[127] ? LFSR_POLY : 128'h0);
  endfunction

  function automatic logic [127:0] corner_pat(input logic [1:0] i);
    logic [127:0] p;
    case (i)
      2'd0:    p = CORNER_ZERO;
      2'd1:    p = CORNER_ONES;
      2'd2:    p = CORNER_FIVE;
      default: p = CORNER_A;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/cosim_lfsr128.sv
// cosim_lfsr128: 128-bit Galois LFSR register.
//   clk   : clock (rising edge)
//   rst_n : asynchronous active-low reset, state returns to SEED
//   load  : copy seed into the register (wins over step)
//   seed  : value loaded when load=1
//   step  : advance one LFSR step
//   q     : current LFSR state
module cosim_lfsr128
  import cosim_pkg::*;
#(
  parameter logic [127:0] SEED = 128'h1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [127:0] seed,
  input  logic         step,
  output logic [127:0] q
);

  logic [127:0] q_q;
  logic [127:0] q_d;

  always_comb begin
    q_d = q_q;
    if (load) begin
      q_d = seed;
    end else if (step) begin
      q_d = lfsr128_next(q_q);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_q <= SEED;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/cosim_vec_gen.sv
// cosim_vec_gen: streams a run of stimulus vectors to a downstream comparator.
// A run is four fixed corner words followed by NUM_RANDOM LFSR words, the
// first of which is SEED itself.
//   clk       : clock (rising edge)
//   rst_n     : asynchronous active-low reset
//   start     : begin a run (honoured only when idle or done)
//   vec_valid : vec_data/vec_idx hold a vector
//   vec_ready : downstream accepts the vector this cycle
//   vec_data  : 128-bit stimulus word
//   vec_idx   : index of the vector on vec_data
//   done      : the run has completed
module cosim_vec_gen
  import cosim_pkg::*;
#(
  parameter int unsigned  NUM_RANDOM = 1000,
  parameter logic [127:0] SEED       = 128'h1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  output logic         vec_valid,
  input  logic         vec_ready,
  output logic [127:0] vec_data,
  output logic [15:0]  vec_idx,
  output logic         done
);

  // Index of the final vector of a run.
  localparam logic [15:0] LAST_IDX = 16'(3 + NUM_RANDOM);

  state_e       state_q, state_d;
  logic         vec_valid_q, vec_valid_d;
  logic [127:0] vec_data_q, vec_data_d;
  logic [15:0]  vec_idx_q, vec_idx_d;
  logic         done_q, done_d;

  logic         lfsr_load;
  logic         lfsr_step;
  logic [127:0] lfsr_q;
  logic         accept;

  // vec_valid comes straight from a flop, so it never depends on vec_ready.
  assign accept = vec_valid_q & vec_ready;

  cosim_lfsr128 #(
    .SEED(SEED)
  ) u_lfsr (
    .clk  (clk),
    .rst_n(rst_n),
    .load (lfsr_load),
    .seed (SEED),
    .step (lfsr_step),
    .q    (lfsr_q)
  );

  always_comb begin
    state_d     = state_q;
    vec_valid_d = vec_valid_q;
    vec_data_d  = vec_data_q;
    vec_idx_d   = vec_idx_q;
    done_d      = done_q;
    lfsr_load   = 1'b0;
    lfsr_step   = 1'b0;

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d     = CORNER;
          lfsr_load   = 1'b1;
          vec_idx_d   = 16'd0;
          done_d      = 1'b0;
          vec_valid_d = 1'b1;
          vec_data_d  = CORNER_ZERO;
        end
      end

      CORNER: begin
        if (accept) begin
          vec_idx_d = vec_idx_q + 16'd1;
          if (vec_idx_q[1:0] == 2'd3) begin
            // The LFSR was reloaded at start and has not moved, so it
            // still holds SEED: the first random word.
            state_d    = RANDOM;
            vec_data_d = lfsr_q;
          end else begin
            vec_data_d = corner_pat(vec_idx_q[1:0] + 2'd1);
          end
        end
      end

      RANDOM: begin
        if (accept) begin
          if (vec_idx_q == LAST_IDX) begin
            // Data and index are left as they are so the last vector
            // remains visible after the run ends.
            state_d     = DONE;
            vec_valid_d = 1'b0;
            done_d      = 1'b1;
          end else begin
            // The LFSR tracks vec_data, so stepping it and presenting
            // its successor keep the two in lock-step.
            lfsr_step  = 1'b1;
            vec_idx_d  = vec_idx_q + 16'd1;
            vec_data_d = lfsr128_next(lfsr_q);
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      vec_valid_q <= 1'b0;
      vec_data_q  <= 128'h0;
      vec_idx_q   <= 16'd0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      vec_valid_q <= vec_valid_d;
      vec_data_q  <= vec_data_d;
      vec_idx_q   <= vec_idx_d;
      done_q      <= done_d;
    end
  end

  assign vec_valid = vec_valid_q;
  assign vec_data  = vec_data_q;
  assign vec_idx   = vec_idx_q;
  assign done      = done_q;

endmodule
